// File: rtl/puf_response_sequencer.sv
// Purpose: sequences an RO-PUF array through a range of challenges. For each
// challenge it resets the RO counters, enables the oscillators for a fixed
// window, waits for the counts to settle, then turns the nine counts into an
// 8-bit response and presents it on a valid/ready interface.
// Ports:
//   CLK, reset        - clock, synchronous active-high reset
//   start             - begin a sweep (honoured only when idle)
//   counts[143:0]     - nine 16-bit RO counts, RO k at [16k+15:16k]
//   challenge[5:0]    - challenge driven to every RO instance
//   ro_reset          - counter reset to every RO instance
//   ro_enable         - oscillator enable to every RO instance
//   busy, done        - sweep in progress / last response accepted pulse
//   resp_valid/ready  - response handshake
//   resp_chal/bits/sat - response payload
module puf_response_sequencer #(
  parameter int unsigned WINDOW        = 80000000,
  parameter int unsigned RST_CYCLES    = 4,
  parameter int unsigned SETTLE_CYCLES = 8,
  parameter int unsigned FIRST_CHAL    = 0,
  parameter int unsigned LAST_CHAL     = 63
) (
  input  logic         CLK,
  input  logic         reset,
  input  logic         start,
  input  logic [143:0] counts,
  output logic [5:0]   challenge,
  output logic         ro_reset,
  output logic         ro_enable,
  output logic         busy,
  output logic         done,
  output logic         resp_valid,
  input  logic         resp_ready,
  output logic [5:0]   resp_chal,
  output logic [7:0]   resp_bits,
  output logic         resp_sat
);

  localparam int unsigned NUM_RO = 9;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned CHAL_W = 6;
  localparam int unsigned RESP_W = 8;
  localparam int unsigned TMR_W  = 27;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_RST    = 3'd1;
  localparam logic [2:0] ST_MEAS   = 3'd2;
  localparam logic [2:0] ST_SETTLE = 3'd3;
  localparam logic [2:0] ST_CAPT   = 3'd4;
  localparam logic [2:0] ST_OUT    = 3'd5;
  localparam logic [2:0] ST_DONE   = 3'd6;

  // Terminal timer values: a state lasting N cycles exits when the timer reads N-1.
  localparam logic [TMR_W-1:0] RST_LAST    = TMR_W'(RST_CYCLES - 1);
  localparam logic [TMR_W-1:0] WIN_LAST    = TMR_W'(WINDOW - 1);
  localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [CHAL_W-1:0] CHAL_FIRST = CHAL_W'(FIRST_CHAL);
  localparam logic [CHAL_W-1:0] CHAL_LAST  = CHAL_W'(LAST_CHAL);

  logic [2:0]        state_q,      state_d;
  logic [TMR_W-1:0]  timer_q,      timer_d;
  logic [CHAL_W-1:0] challenge_q,  challenge_d;
  logic              ro_reset_q,   ro_reset_d;
  logic              ro_enable_q,  ro_enable_d;
  logic              busy_q,       busy_d;
  logic              done_q,       done_d;
  logic              resp_valid_q, resp_valid_d;
  logic [CHAL_W-1:0] resp_chal_q,  resp_chal_d;
  logic [RESP_W-1:0] resp_bits_q,  resp_bits_d;
  logic              resp_sat_q,   resp_sat_d;

  // Next-state, timer, payload capture and registered-output decode.
  always_comb begin
    state_d     = state_q;
    timer_d     = '0;
    challenge_d = challenge_q;
    resp_chal_d = resp_chal_q;
    resp_bits_d = resp_bits_q;
    resp_sat_d  = resp_sat_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_RST;
          challenge_d = CHAL_FIRST;
        end
      end
      ST_RST: begin
        timer_d = timer_q + 1'b1;
        if (timer_q == RST_LAST) state_d = ST_MEAS;
      end
      ST_MEAS: begin
        timer_d = timer_q + 1'b1;
        if (timer_q == WIN_LAST) state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        timer_d = timer_q + 1'b1;
        if (timer_q == SETTLE_LAST) state_d = ST_CAPT;
      end
      ST_CAPT: begin
        // Adjacent-pair unsigned compare; ties resolve to 0.
        for (int i = 0; i < int'(RESP_W); i++) begin
          resp_bits_d[i] = counts[CNT_W*i +: CNT_W] > counts[CNT_W*(i+1) +: CNT_W];
        end
        resp_sat_d = 1'b0;
        for (int k = 0; k < int'(NUM_RO); k++) begin
          resp_sat_d = resp_sat_d | (counts[CNT_W*k +: CNT_W] == {CNT_W{1'b1}});
        end
        resp_chal_d = challenge_q;
        state_d     = ST_OUT;
      end
      ST_OUT: begin
        if (resp_valid_q && resp_ready) begin
          if (challenge_q == CHAL_LAST) begin
            state_d = ST_DONE;
          end else begin
            challenge_d = challenge_q + 1'b1;
            state_d     = ST_RST;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Shared timer restarts on every state entry.
    if (state_d != state_q) timer_d = '0;

    // Outputs are registered from the upcoming state so they align with it.
    ro_reset_d   = (state_d == ST_IDLE) || (state_d == ST_RST);
    ro_enable_d  = (state_d == ST_MEAS);
    busy_d       = (state_d != ST_IDLE);
    done_d       = (state_d == ST_DONE);
    resp_valid_d = (state_d == ST_OUT);
  end

  // State and output registers.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      timer_q      <= '0;
      challenge_q  <= CHAL_FIRST;
      ro_reset_q   <= 1'b1;
      ro_enable_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_chal_q  <= '0;
      resp_bits_q  <= '0;
      resp_sat_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      challenge_q  <= challenge_d;
      ro_reset_q   <= ro_reset_d;
      ro_enable_q  <= ro_enable_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      resp_valid_q <= resp_valid_d;
      resp_chal_q  <= resp_chal_d;
      resp_bits_q  <= resp_bits_d;
      resp_sat_q   <= resp_sat_d;
    end
  end

  assign challenge  = challenge_q;
  assign ro_reset   = ro_reset_q;
  assign ro_enable  = ro_enable_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign resp_valid = resp_valid_q;
  assign resp_chal  = resp_chal_q;
  assign resp_bits  = resp_bits_q;
  assign resp_sat   = resp_sat_q;

endmodule

// File: tb/tb_puf_response_sequencer.sv
// Bench for puf_response_sequencer: a single-challenge instance (a) and a
// full-sweep instance (b). Expected responses are queued by the stimulus and
// popped by per-instance monitors on every handshake.
module tb_puf_response_sequencer;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic         reset_a, start_a, resp_ready_a;
  logic [143:0] counts_a;
  logic [5:0]   challenge_a, resp_chal_a;
  logic         ro_reset_a, ro_enable_a, busy_a, done_a, resp_valid_a, resp_sat_a;
  logic [7:0]   resp_bits_a;

  logic         reset_b, start_b, resp_ready_b;
  logic [143:0] counts_b;
  logic [5:0]   challenge_b, resp_chal_b;
  logic         ro_reset_b, ro_enable_b, busy_b, done_b, resp_valid_b, resp_sat_b;
  logic [7:0]   resp_bits_b;

  puf_response_sequencer #(
    .WINDOW(10), .RST_CYCLES(2), .SETTLE_CYCLES(3), .FIRST_CHAL(5), .LAST_CHAL(5)
  ) u_a (
    .CLK(CLK), .reset(reset_a), .start(start_a), .counts(counts_a),
    .challenge(challenge_a), .ro_reset(ro_reset_a), .ro_enable(ro_enable_a),
    .busy(busy_a), .done(done_a), .resp_valid(resp_valid_a), .resp_ready(resp_ready_a),
    .resp_chal(resp_chal_a), .resp_bits(resp_bits_a), .resp_sat(resp_sat_a)
  );

  puf_response_sequencer #(
    .WINDOW(4), .RST_CYCLES(1), .SETTLE_CYCLES(1), .FIRST_CHAL(0), .LAST_CHAL(63)
  ) u_b (
    .CLK(CLK), .reset(reset_b), .start(start_b), .counts(counts_b),
    .challenge(challenge_b), .ro_reset(ro_reset_b), .ro_enable(ro_enable_b),
    .busy(busy_b), .done(done_b), .resp_valid(resp_valid_b), .resp_ready(resp_ready_b),
    .resp_chal(resp_chal_b), .resp_bits(resp_bits_b), .resp_sat(resp_sat_b)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int hs_b     = 0;
  logic [14:0] exp_a[$];   // {chal[5:0], bits[7:0], sat}
  logic [14:0] exp_b[$];

  // Counts are listed RO8 first so RO0 lands in the low bits.
  localparam logic [143:0] CNT_BASIC = {16'd5, 16'd10, 16'd40, 16'd30, 16'd20,
                                        16'd95, 16'd95, 16'd90, 16'd100};
  localparam logic [143:0] CNT_SAT   = {16'd1, 16'd50, 16'd50, 16'd7, 16'd5,
                                        16'hFFFF, 16'd30, 16'd20, 16'd10};
  localparam logic [143:0] CNT_ALT   = {16'd5, 16'd1, 16'd5, 16'd1, 16'd5,
                                        16'd1, 16'd5, 16'd1, 16'd5};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Monitor for instance a: compare payload on every handshake.
  always @(negedge CLK) begin
    if (resp_valid_a && resp_ready_a) begin
      if (exp_a.size() == 0) begin
        n_checks++;
        $display("FAIL a_unexpected_resp: got chal 0x%0h with no queued expectation", resp_chal_a);
      end else begin
        logic [14:0] e;
        e = exp_a.pop_front();
        check("a_resp_chal", 32'(resp_chal_a), 32'(e[14:9]));
        check("a_resp_bits", 32'(resp_bits_a), 32'(e[8:1]));
        check("a_resp_sat",  32'(resp_sat_a),  32'(e[0]));
      end
    end
  end

  // Monitor for instance b.
  always @(negedge CLK) begin
    if (resp_valid_b && resp_ready_b) begin
      hs_b++;
      if (exp_b.size() == 0) begin
        n_checks++;
        $display("FAIL b_unexpected_resp: got chal 0x%0h with no queued expectation", resp_chal_b);
      end else begin
        logic [14:0] e;
        e = exp_b.pop_front();
        check("b_resp_chal", 32'(resp_chal_b), 32'(e[14:9]));
        check("b_resp_bits", 32'(resp_bits_b), 32'(e[8:1]));
        check("b_resp_sat",  32'(resp_sat_b),  32'(e[0]));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // One sweep on instance a; optionally re-pulses start mid-window.
  task automatic run_a(input bit dbl_start, output int lat);
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    check("a_busy_on_start", 32'(busy_a), 32'd1);
    check("a_chal_on_start", 32'(challenge_a), 32'd5);
    check("a_ro_reset_in_rst", 32'(ro_reset_a), 32'd1);
    lat = 0;
    while (!resp_valid_a && lat < 200) begin
      tick();
      lat++;
      start_a = (dbl_start && lat == 6);
      if (lat == 5) begin
        check("a_ro_enable_meas", 32'(ro_enable_a), 32'd1);
        check("a_ro_reset_meas",  32'(ro_reset_a),  32'd0);
      end
    end
    start_a = 1'b0;
    check("a_valid_latency", 32'(lat), 32'd16);
    tick();
    check("a_done_pulse", 32'(done_a), 32'd1);
    check("a_valid_drop", 32'(resp_valid_a), 32'd0);
    tick();
    check("a_done_clear", 32'(done_a), 32'd0);
    check("a_idle_busy",  32'(busy_a), 32'd0);
    check("a_chal_hold",  32'(challenge_a), 32'd5);
  endtask

  initial begin
    int lat, n, bad;
    bit saw;
    logic [7:0] snap_bits;

    reset_a = 1'b1; reset_b = 1'b1; start_a = 1'b0; start_b = 1'b0;
    resp_ready_a = 1'b1; resp_ready_b = 1'b1;
    counts_a = CNT_BASIC; counts_b = CNT_ALT;
    repeat (3) tick();

    // Reset values.
    check("rst_challenge",  32'(challenge_a),  32'd5);
    check("rst_ro_reset",   32'(ro_reset_a),   32'd1);
    check("rst_ro_enable",  32'(ro_enable_a),  32'd0);
    check("rst_busy",       32'(busy_a),       32'd0);
    check("rst_done",       32'(done_a),       32'd0);
    check("rst_resp_valid", 32'(resp_valid_a), 32'd0);
    check("rst_resp_chal",  32'(resp_chal_a),  32'd0);
    check("rst_resp_bits",  32'(resp_bits_a),  32'd0);
    check("rst_resp_sat",   32'(resp_sat_a),   32'd0);

    // start coincident with reset is dropped.
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    check("start_with_reset_busy", 32'(busy_a), 32'd0);
    reset_a = 1'b0; reset_b = 1'b0;
    tick();
    check("idle_after_reset_busy", 32'(busy_a), 32'd0);

    // Basic single challenge.
    exp_a.push_back({6'd5, 8'hC9, 1'b0});
    run_a(1'b0, lat);

    // Saturation and ties, with a second start during MEAS.
    counts_a = CNT_SAT;
    exp_a.push_back({6'd5, 8'h88, 1'b1});
    run_a(1'b1, lat);
    check("a_queue_drained_after_dbl_start", 32'(exp_a.size()), 32'd0);

    // Reset in the middle of the measurement window.
    counts_a = CNT_BASIC;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    check("a_pre_reset_enable", 32'(ro_enable_a), 32'd1);
    reset_a = 1'b1;
    tick();
    check("a_midmeas_ro_enable", 32'(ro_enable_a), 32'd0);
    check("a_midmeas_ro_reset",  32'(ro_reset_a),  32'd1);
    check("a_midmeas_busy",      32'(busy_a),      32'd0);
    reset_a = 1'b0;
    saw = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      saw = saw | resp_valid_a;
    end
    check("a_no_resp_after_reset", 32'(saw), 32'd0);
    exp_a.push_back({6'd5, 8'hC9, 1'b0});
    run_a(1'b0, lat);

    // Full sweep on b with a 50-cycle stall at challenge 10.
    for (int i = 0; i < 64; i++) exp_b.push_back({6'(i), 8'h55, 1'b0});
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    check("b_first_chal", 32'(challenge_b), 32'd0);
    n = 0;
    while (challenge_b != 6'd10 && n < 2000) begin
      tick();
      n++;
    end
    resp_ready_b = 1'b0;
    n = 0;
    while (!resp_valid_b && n < 200) begin
      tick();
      n++;
    end
    check("b_stall_valid_seen", 32'(resp_valid_b), 32'd1);
    check("b_stall_chal", 32'(resp_chal_b), 32'd10);
    snap_bits = resp_bits_b;
    bad = 0;
    for (int k = 1; k <= 51; k++) begin
      if (!(resp_valid_b && resp_bits_b == snap_bits && resp_chal_b == 6'd10 &&
            !ro_enable_b && challenge_b == 6'd10)) bad++;
      if (k < 51) tick();
    end
    check("b_stall_stable_cycles_bad", 32'(bad), 32'd0);
    resp_ready_b = 1'b1;
    tick();
    check("b_after_accept_rst",   32'(ro_reset_b),   32'd1);
    check("b_after_accept_busy",  32'(busy_b),       32'd1);
    check("b_after_accept_valid", 32'(resp_valid_b), 32'd0);
    check("b_after_accept_chal",  32'(challenge_b),  32'd11);
    n = 0;
    while (!done_b && n < 2000) begin
      tick();
      n++;
    end
    check("b_done_seen", 32'(done_b), 32'd1);
    check("b_handshakes", 32'(hs_b), 32'd64);
    check("b_last_chal", 32'(challenge_b), 32'd63);
    tick();
    check("b_done_clear", 32'(done_b), 32'd0);
    check("b_idle_busy",  32'(busy_b), 32'd0);
    check("b_queue_drained", 32'(exp_b.size()), 32'd0);
    check("a_queue_drained", 32'(exp_a.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/puf_response_sequencer.md
Name: puf_response_sequencer

Overview:
- Controller directly upstream and downstream of the 9-instance RO_withCounter array: drives the 6-bit challenge, counter reset and oscillator enable, and replaces the free-running timerCounter/switch-driven flow.
- Sweeps a range of challenges automatically. For each challenge: resets the counters, enables the ROs for a fixed window, lets counts settle, then compares adjacent counts into an 8-bit response.
- Emits one response word per challenge on a valid/ready interface, for UART or LED/SSEG consumers.

Parameters:
- WINDOW, 80000000: CLK cycles the ROs are enabled per challenge (≥1).
- RST_CYCLES, 4: CLK cycles ro_reset is held high before each window (≥1).
- SETTLE_CYCLES, 8: CLK cycles between enable deassertion and count capture (≥1); covers async RO-domain counter settling.
- FIRST_CHAL, 0: first challenge of a sweep (0..63).
- LAST_CHAL, 63: last challenge of a sweep (FIRST_CHAL ≤ LAST_CHAL ≤ 63).

Ports:
- CLK  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  single-cycle request to begin a sweep; honoured only in IDLE.
- counts  input  144  nine 16-bit RO counts; RO k at bits [16k+15:16k].
- challenge  output  6  {sel[2:0], bx[2:0]} to all RO instances.
- ro_reset  output  1  counter reset to all RO instances.
- ro_enable  output  1  oscillator enable to all RO instances.
- busy  output  1  high whenever state ≠ IDLE.
- done  output  1  one-cycle pulse when the last response of a sweep is accepted.
- resp_valid  output  1  response word available.
- resp_ready  input  1  consumer accepts the word.
- resp_chal  output  6  challenge that produced resp_bits.
- resp_bits  output  8  bit i = (count[i] > count[i+1]), unsigned.
- resp_sat  output  1  at least one of the nine counts equals 16'hFFFF at capture.

Behaviour:
- Clock and reset: one clock, CLK. reset is synchronous, active-high, and returns the block to IDLE from any state.
- Reset values: challenge=FIRST_CHAL, ro_reset=1, ro_enable=0, busy=0, done=0, resp_valid=0, resp_chal=0, resp_bits=0, resp_sat=0.
- States: IDLE, RST, MEAS, SETTLE, CAPT, OUT, DONE.
- IDLE:
  - ro_reset=1, ro_enable=0.
  - start=1 → RST next cycle, with challenge loaded to FIRST_CHAL.
  - start while busy is ignored.
- RST: ro_reset=1, ro_enable=0, challenge stable. After exactly RST_CYCLES cycles → MEAS.
- MEAS: ro_reset=0, ro_enable=1 for exactly WINDOW cycles → SETTLE. A single 27-bit cycle timer is shared across RST/MEAS/SETTLE and cleared on every state entry.
- SETTLE: ro_enable=0, ro_reset=0 for SETTLE_CYCLES cycles → CAPT.
- CAPT: one cycle.
  - Registers resp_bits from counts, resp_sat, and resp_chal=challenge.
  - Comparison is strictly unsigned greater-than; equal counts give 0.
  - → OUT.
- OUT:
  - resp_valid=1; resp_chal/resp_bits/resp_sat stay stable until the handshake.
  - Handshake occurs on a cycle with resp_valid & resp_ready. On that cycle:
    - if challenge==LAST_CHAL → DONE;
    - else challenge increments by 1 → RST.
  - resp_valid drops the following cycle. resp_ready may be held high continuously, giving one word per challenge.
  - ro_enable stays 0 throughout OUT.
- DONE: done=1 for one cycle → IDLE. challenge holds LAST_CHAL until the next start.
- Timing per challenge: RST_CYCLES+WINDOW+SETTLE_CYCLES+1 cycles from RST entry to resp_valid rising, plus consumer stall time.
- Challenge never wraps past 63. FIRST_CHAL==LAST_CHAL gives exactly one response.
- resp_ready outside OUT is ignored.
- Reset asserted mid-MEAS: ro_enable=0 and ro_reset=1 on the next edge, and no response is emitted.
- start coincident with reset: reset wins.

Test Plan:
- Basic single challenge: WINDOW=10, RST_CYCLES=2, SETTLE_CYCLES=3, FIRST=LAST=5, resp_ready=1, pulse start, model counts 100,90,95,95,20,30,40,10,5 → resp_chal=5, resp_bits=8'b1100_1001 (bit0 first, LSB-first: 1,0,0,1,0,0,1,1), resp_sat=0; resp_valid rises 16 cycles after RST entry; done pulses 1 cycle after accept.
- Full sweep: FIRST=0, LAST=63, resp_ready=1 → exactly 64 handshakes with resp_chal 0..63 in order, then one done pulse, then busy=0.
- Backpressure: resp_ready low for 50 cycles in OUT → resp_valid, resp_bits and resp_chal held constant, ro_enable=0, challenge unchanged; accept on the 51st cycle → next RST.
- Saturation and ties: count[3]=16'hFFFF and count[6]=count[7] → resp_sat=1 and resp_bits[6]=0.
- Reset mid-MEAS: assert reset at cycle 5 of the window → next edge ro_enable=0, ro_reset=1, busy=0; no resp_valid; a new start restarts at FIRST_CHAL.
- Start while busy: second start pulse during MEAS → no effect on challenge, timer, or response count.
